// File: rtl/cpu_exec_unit_if.sv
`default_nettype none
// ============================================================================
// Module : cpu_exec_unit_if
// Brief  : Decode-to-execute bus for cpu_exec_unit (decode inputs, E results).
// Rev    : 1.0 - initial release
// ============================================================================
interface cpu_exec_unit_if;
    logic        flush_e;
    logic [31:0] instr_d;
    logic [31:0] pc_d;
    logic [31:0] imm_ext_d;
    logic [31:0] rd1_fw_e;
    logic [31:0] rd2_fw_e;
    logic [31:0] csrd_fw_e;
    logic [2:0]  imm_src_d;
    logic        reg_write_e;
    logic        csr_write_e;
    logic        illegal_instr_e;
    logic [2:0]  result_src_e;
    logic [3:0]  mem_write_e;
    logic [2:0]  data_ext_control_e;
    logic [4:0]  rs1_e;
    logic [4:0]  rs2_e;
    logic [4:0]  rd_e;
    logic [11:0] csrs_e;
    logic [31:0] alu_result_e;
    logic [31:0] pc_target_e;
    logic [1:0]  pc_src_e;

    modport master (
        output flush_e, instr_d, pc_d, imm_ext_d, rd1_fw_e, rd2_fw_e, csrd_fw_e,
        input  imm_src_d, reg_write_e, csr_write_e, illegal_instr_e, result_src_e,
               mem_write_e, data_ext_control_e, rs1_e, rs2_e, rd_e, csrs_e,
               alu_result_e, pc_target_e, pc_src_e
    );

    modport slave (
        input  flush_e, instr_d, pc_d, imm_ext_d, rd1_fw_e, rd2_fw_e, csrd_fw_e,
        output imm_src_d, reg_write_e, csr_write_e, illegal_instr_e, result_src_e,
               mem_write_e, data_ext_control_e, rs1_e, rs2_e, rd_e, csrs_e,
               alu_result_e, pc_target_e, pc_src_e
    );
endinterface
`default_nettype wire

// File: rtl/cpu_exec_unit.sv
`default_nettype none
// ============================================================================
// Module : cpu_exec_unit
// Brief  : RV32I decode, D/E pipeline register, ALU and branch resolution.
// Rev    : 1.0 - initial release
// ============================================================================
module cpu_exec_unit (
    input  logic          clk,
    input  logic          rst_n,
    cpu_exec_unit_if.slave bus
);
    localparam logic [6:0] c_OP_R      = 7'b0110011;
    localparam logic [6:0] c_OP_I      = 7'b0010011;
    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;
    localparam logic [6:0] c_OP_JALR   = 7'b1100111;
    localparam logic [6:0] c_OP_LUI    = 7'b0110111;
    localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] c_OP_FENCE  = 7'b0001111;
    localparam logic [6:0] c_OP_SYSTEM = 7'b1110011;

    localparam logic [3:0] c_ALU_ADD  = 4'd0;
    localparam logic [3:0] c_ALU_SUB  = 4'd1;
    localparam logic [3:0] c_ALU_AND  = 4'd2;
    localparam logic [3:0] c_ALU_OR   = 4'd3;
    localparam logic [3:0] c_ALU_XOR  = 4'd4;
    localparam logic [3:0] c_ALU_SLL  = 4'd5;
    localparam logic [3:0] c_ALU_SRL  = 4'd6;
    localparam logic [3:0] c_ALU_SRA  = 4'd7;
    localparam logic [3:0] c_ALU_SLT  = 4'd8;
    localparam logic [3:0] c_ALU_SLTU = 4'd9;
    localparam logic [3:0] c_ALU_PASS = 4'd10;
    localparam logic [3:0] c_ALU_ANDN = 4'd11;

    localparam logic [2:0] c_RES_ALU    = 3'd0;
    localparam logic [2:0] c_RES_DATA   = 3'd1;
    localparam logic [2:0] c_RES_PC4    = 3'd2;
    localparam logic [2:0] c_RES_TARGET = 3'd3;
    localparam logic [2:0] c_RES_CSR    = 3'd4;

    localparam logic [2:0] c_IMM_I = 3'd0;
    localparam logic [2:0] c_IMM_S = 3'd1;
    localparam logic [2:0] c_IMM_B = 3'd2;
    localparam logic [2:0] c_IMM_U = 3'd3;
    localparam logic [2:0] c_IMM_J = 3'd4;

    localparam logic [1:0] c_SRCB_RD2 = 2'd0;
    localparam logic [1:0] c_SRCB_IMM = 2'd1;
    localparam logic [1:0] c_SRCB_RD1 = 2'd2;
    localparam logic [1:0] c_SRCB_RS1 = 2'd3;

    localparam logic       c_JSRC_TARGET = 1'b0;
    localparam logic       c_JSRC_ALU    = 1'b1;
    localparam logic [6:0] c_F7_ZERO     = 7'b0000000;
    localparam logic [6:0] c_F7_ALT      = 7'b0100000;

    // Integer op from funct3; alt selects SUB/SRA.
    function automatic logic [3:0] f_int_op(input logic [2:0] funct3, input logic alt);
        case (funct3)
            3'b000:  f_int_op = alt ? c_ALU_SUB : c_ALU_ADD;
            3'b001:  f_int_op = c_ALU_SLL;
            3'b010:  f_int_op = c_ALU_SLT;
            3'b011:  f_int_op = c_ALU_SLTU;
            3'b100:  f_int_op = c_ALU_XOR;
            3'b101:  f_int_op = alt ? c_ALU_SRA : c_ALU_SRL;
            3'b110:  f_int_op = c_ALU_OR;
            default: f_int_op = c_ALU_AND;
        endcase
    endfunction

    logic [6:0] w_op;
    logic [2:0] w_funct3;
    logic       w_f7_zero;
    logic       w_f7_alt;
    assign w_op      = bus.instr_d[6:0];
    assign w_funct3  = bus.instr_d[14:12];
    assign w_f7_zero = (bus.instr_d[31:25] == c_F7_ZERO);
    assign w_f7_alt  = (bus.instr_d[31:25] == c_F7_ALT);

    logic       w_bad;
    logic       w_reg_write, w_csr_write, w_illegal, w_branch, w_jump, w_jump_src, w_src_a;
    logic [3:0] w_mem_write, w_alu_ctrl;
    logic [2:0] w_result_src, w_imm_src, w_data_ext, w_branch_cond;
    logic [1:0] w_src_b;

    always_comb begin
        w_bad         = 1'b0;
        w_reg_write   = 1'b0;
        w_csr_write   = 1'b0;
        w_illegal     = 1'b0;
        w_branch      = 1'b0;
        w_jump        = 1'b0;
        w_jump_src    = c_JSRC_TARGET;
        w_src_a       = 1'b0;
        w_mem_write   = 4'b0000;
        w_alu_ctrl    = c_ALU_ADD;
        w_result_src  = c_RES_ALU;
        w_imm_src     = c_IMM_I;
        w_data_ext    = 3'd0;
        w_branch_cond = 3'd0;
        w_src_b       = c_SRCB_RD2;
        case (w_op)
            c_OP_R: begin
                w_reg_write = 1'b1;
                w_alu_ctrl  = f_int_op(w_funct3, w_f7_alt);
                w_bad = !(w_f7_zero || (w_f7_alt && (w_funct3 == 3'b000 || w_funct3 == 3'b101)));
            end
            c_OP_I: begin
                w_reg_write = 1'b1;
                w_src_b     = c_SRCB_IMM;
                w_alu_ctrl  = f_int_op(w_funct3, (w_funct3 == 3'b101) && w_f7_alt);
                // Only the shift immediates constrain funct7.
                if (w_funct3 == 3'b001)
                    w_bad = !w_f7_zero;
                else if (w_funct3 == 3'b101)
                    w_bad = !(w_f7_zero || w_f7_alt);
            end
            c_OP_LOAD: begin
                w_reg_write  = 1'b1;
                w_src_b      = c_SRCB_IMM;
                w_result_src = c_RES_DATA;
                w_data_ext   = w_funct3;
                w_bad = (w_funct3 == 3'b011) || (w_funct3 == 3'b110) || (w_funct3 == 3'b111);
            end
            c_OP_STORE: begin
                w_src_b   = c_SRCB_IMM;
                w_imm_src = c_IMM_S;
                case (w_funct3)
                    3'b000:  w_mem_write = 4'b0001;
                    3'b001:  w_mem_write = 4'b0011;
                    3'b010:  w_mem_write = 4'b1111;
                    default: w_bad = 1'b1;
                endcase
            end
            c_OP_BRANCH: begin
                w_alu_ctrl    = c_ALU_SUB;
                w_imm_src     = c_IMM_B;
                w_branch      = 1'b1;
                w_branch_cond = w_funct3;
            end
            c_OP_JAL: begin
                w_reg_write  = 1'b1;
                w_jump       = 1'b1;
                w_jump_src   = c_JSRC_TARGET;
                w_result_src = c_RES_PC4;
                w_imm_src    = c_IMM_J;
            end
            c_OP_JALR: begin
                w_reg_write  = 1'b1;
                w_src_b      = c_SRCB_IMM;
                w_jump       = 1'b1;
                w_jump_src   = c_JSRC_ALU;
                w_result_src = c_RES_PC4;
                w_bad        = (w_funct3 != 3'b000);
            end
            c_OP_LUI: begin
                w_reg_write = 1'b1;
                w_alu_ctrl  = c_ALU_PASS;
                w_src_b     = c_SRCB_IMM;
                w_imm_src   = c_IMM_U;
            end
            c_OP_AUIPC: begin
                w_reg_write  = 1'b1;
                w_result_src = c_RES_TARGET;
                w_imm_src    = c_IMM_U;
            end
            c_OP_FENCE: begin
                w_bad = 1'b0;
            end
            c_OP_SYSTEM: begin
                w_reg_write  = 1'b1;
                w_csr_write  = 1'b1;
                w_src_a      = 1'b1;
                w_result_src = c_RES_CSR;
                w_src_b      = w_funct3[2] ? c_SRCB_RS1 : c_SRCB_RD1;
                // funct3[1:0]==00 covers ECALL/EBREAK and the reserved 100.
                case (w_funct3[1:0])
                    2'b01:   w_alu_ctrl = c_ALU_PASS;
                    2'b10:   w_alu_ctrl = c_ALU_OR;
                    2'b11:   w_alu_ctrl = c_ALU_ANDN;
                    default: w_bad = 1'b1;
                endcase
            end
            default: w_bad = 1'b1;
        endcase
        if (w_bad) begin
            w_illegal    = 1'b1;
            w_reg_write  = 1'b0;
            w_csr_write  = 1'b0;
            w_mem_write  = 4'b0000;
            w_jump       = 1'b0;
            w_branch     = 1'b0;
            w_result_src = c_RES_ALU;
            w_imm_src    = c_IMM_I;
            w_data_ext   = 3'd0;
        end
    end

    assign bus.imm_src_d = w_imm_src;

    logic        r_reg_write, r_csr_write, r_illegal, r_branch, r_jump, r_jump_src, r_src_a;
    logic [3:0]  r_mem_write, r_alu_ctrl;
    logic [2:0]  r_result_src, r_data_ext, r_branch_cond;
    logic [1:0]  r_src_b;
    logic [4:0]  r_rs1, r_rs2, r_rd;
    logic [11:0] r_csrs;
    logic [31:0] r_pc, r_imm_ext;

    always_ff @(posedge clk) begin
        if (!rst_n || bus.flush_e) begin
            r_reg_write   <= 1'b0;
            r_csr_write   <= 1'b0;
            r_illegal     <= 1'b0;
            r_branch      <= 1'b0;
            r_jump        <= 1'b0;
            r_jump_src    <= 1'b0;
            r_src_a       <= 1'b0;
            r_mem_write   <= 4'b0000;
            r_alu_ctrl    <= 4'd0;
            r_result_src  <= c_RES_ALU;
            r_data_ext    <= 3'd0;
            r_branch_cond <= 3'd0;
            r_src_b       <= 2'd0;
            r_rs1         <= 5'd0;
            r_rs2         <= 5'd0;
            r_rd          <= 5'd0;
            r_csrs        <= 12'd0;
            r_pc          <= 32'd0;
            r_imm_ext     <= 32'd0;
        end else begin
            r_reg_write   <= w_reg_write;
            r_csr_write   <= w_csr_write;
            r_illegal     <= w_illegal;
            r_branch      <= w_branch;
            r_jump        <= w_jump;
            r_jump_src    <= w_jump_src;
            r_src_a       <= w_src_a;
            r_mem_write   <= w_mem_write;
            r_alu_ctrl    <= w_alu_ctrl;
            r_result_src  <= w_result_src;
            r_data_ext    <= w_data_ext;
            r_branch_cond <= w_branch_cond;
            r_src_b       <= w_src_b;
            r_rs1         <= bus.instr_d[19:15];
            r_rs2         <= bus.instr_d[24:20];
            r_rd          <= bus.instr_d[11:7];
            r_csrs        <= bus.instr_d[31:20];
            r_pc          <= bus.pc_d;
            r_imm_ext     <= bus.imm_ext_d;
        end
    end

    logic [31:0] w_a, w_b, w_b_eff, w_result;
    logic [32:0] w_sum;
    logic [4:0]  w_shamt;
    logic        w_is_sub, w_is_addsub;
    logic        w_zero, w_neg, w_carry, w_ovf, w_taken;

    always_comb begin
        w_a = r_src_a ? bus.csrd_fw_e : bus.rd1_fw_e;
        case (r_src_b)
            c_SRCB_RD2: w_b = bus.rd2_fw_e;
            c_SRCB_IMM: w_b = r_imm_ext;
            c_SRCB_RD1: w_b = bus.rd1_fw_e;
            default:    w_b = {27'd0, r_rs1};
        endcase
    end

    assign w_is_sub    = (r_alu_ctrl == c_ALU_SUB);
    assign w_is_addsub = w_is_sub || (r_alu_ctrl == c_ALU_ADD);
    assign w_b_eff     = w_is_sub ? ~w_b : w_b;
    assign w_sum       = {1'b0, w_a} + {1'b0, w_b_eff} + {32'd0, w_is_sub};
    assign w_shamt     = w_b[4:0];

    always_comb begin
        case (r_alu_ctrl)
            c_ALU_ADD, c_ALU_SUB: w_result = w_sum[31:0];
            c_ALU_AND:  w_result = w_a & w_b;
            c_ALU_OR:   w_result = w_a | w_b;
            c_ALU_XOR:  w_result = w_a ^ w_b;
            c_ALU_SLL:  w_result = w_a << w_shamt;
            c_ALU_SRL:  w_result = w_a >> w_shamt;
            c_ALU_SRA:  w_result = $unsigned($signed(w_a) >>> w_shamt);
            c_ALU_SLT:  w_result = {31'd0, $signed(w_a) < $signed(w_b)};
            c_ALU_SLTU: w_result = {31'd0, w_a < w_b};
            c_ALU_PASS: w_result = w_b;
            c_ALU_ANDN: w_result = w_a & ~w_b;
            default:    w_result = 32'd0;
        endcase
    end

    assign w_zero  = (w_result == 32'd0);
    assign w_neg   = w_result[31];
    assign w_carry = w_sum[32];
    assign w_ovf   = w_is_addsub && (w_a[31] == w_b_eff[31]) && (w_sum[31] != w_a[31]);

    always_comb begin
        case (r_branch_cond)
            3'b000:  w_taken = w_zero;
            3'b001:  w_taken = !w_zero;
            3'b100:  w_taken = w_neg ^ w_ovf;
            3'b101:  w_taken = !(w_neg ^ w_ovf);
            3'b110:  w_taken = !w_carry;
            3'b111:  w_taken = w_carry;
            default: w_taken = 1'b0;
        endcase
    end

    // Jump target bit 0 is left to the fetch side to clear.
    assign bus.pc_src_e = (r_jump && (r_jump_src == c_JSRC_ALU)) ? 2'd2 :
                          (r_jump || (r_branch && w_taken))     ? 2'd1 : 2'd0;

    assign bus.alu_result_e       = w_result;
    assign bus.pc_target_e        = r_pc + r_imm_ext;
    assign bus.reg_write_e        = r_reg_write;
    assign bus.csr_write_e        = r_csr_write;
    assign bus.illegal_instr_e    = r_illegal;
    assign bus.result_src_e       = r_result_src;
    assign bus.mem_write_e        = r_mem_write;
    assign bus.data_ext_control_e = r_data_ext;
    assign bus.rs1_e              = r_rs1;
    assign bus.rs2_e              = r_rs2;
    assign bus.rd_e               = r_rd;
    assign bus.csrs_e             = r_csrs;
endmodule
`default_nettype wire

// File: tb/tb_cpu_exec_unit.sv
`default_nettype none
// ============================================================================
// Module : tb_cpu_exec_unit
// Brief  : Directed and randomized checks of cpu_exec_unit against an ISA model.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_cpu_exec_unit;
    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_fail;
    logic [2:0] imm_src_seen;

    cpu_exec_unit_if bus ();

    cpu_exec_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        illegal;
        logic        reg_write;
        logic        csr_write;
        logic [3:0]  mem_write;
        logic [2:0]  result_src;
        logic [2:0]  data_ext;
        logic [2:0]  imm_src;
        logic [1:0]  pc_src;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [11:0] csrs;
        logic [31:0] alu;
        logic [31:0] pc_target;
        logic        chk_alu;
        logic        chk_imm;
    } exp_t;

    // RV32I integer semantics, written directly from the ISA.
    function automatic logic [31:0] int_op(input logic [2:0] f3, input logic alt,
                                           input logic [31:0] a, input logic [31:0] b);
        case (f3)
            3'd0:    return alt ? a - b : a + b;
            3'd1:    return a << b[4:0];
            3'd2:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3:    return (a < b) ? 32'd1 : 32'd0;
            3'd4:    return a ^ b;
            3'd5:    return alt ? $unsigned($signed(a) >>> b[4:0]) : a >> b[4:0];
            3'd6:    return a | b;
            default: return a & b;
        endcase
    endfunction

    function automatic exp_t ref_model(input logic [31:0] ins, input logic [31:0] pc,
                                       input logic [31:0] imm, input logic [31:0] rd1,
                                       input logic [31:0] rd2, input logic [31:0] csrd,
                                       input logic bubble);
        exp_t e;
        logic legal;
        logic taken;
        logic [2:0] f3;
        logic [6:0] f7;
        logic [31:0] src;
        f3 = ins[14:12];
        f7 = ins[31:25];
        e = '0;
        legal = 1'b1;
        e.chk_alu = 1'b1;
        e.chk_imm = 1'b1;
        e.rs1 = ins[19:15];
        e.rs2 = ins[24:20];
        e.rd = ins[11:7];
        e.csrs = ins[31:20];
        e.pc_target = pc + imm;
        case (ins[6:0])
            7'h33: begin
                legal = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
                e.reg_write = 1'b1;
                e.alu = int_op(f3, f7 == 7'h20, rd1, rd2);
                e.chk_imm = 1'b0;
            end
            7'h13: begin
                if (f3 == 3'd1) legal = (f7 == 7'h00);
                if (f3 == 3'd5) legal = (f7 == 7'h00) || (f7 == 7'h20);
                e.reg_write = 1'b1;
                e.alu = int_op(f3, f3 == 3'd5 && f7 == 7'h20, rd1, imm);
            end
            7'h03: begin
                legal = (f3 != 3'd3) && (f3 != 3'd6) && (f3 != 3'd7);
                e.reg_write = 1'b1;
                e.result_src = 3'd1;
                e.data_ext = f3;
                e.alu = rd1 + imm;
            end
            7'h23: begin
                legal = (f3 <= 3'd2);
                e.mem_write = (f3 == 3'd0) ? 4'b0001 : (f3 == 3'd1) ? 4'b0011 : 4'b1111;
                e.imm_src = 3'd1;
                e.alu = rd1 + imm;
            end
            7'h63: begin
                case (f3)
                    3'd0:    taken = (rd1 == rd2);
                    3'd1:    taken = (rd1 != rd2);
                    3'd4:    taken = ($signed(rd1) < $signed(rd2));
                    3'd5:    taken = ($signed(rd1) >= $signed(rd2));
                    3'd6:    taken = (rd1 < rd2);
                    3'd7:    taken = (rd1 >= rd2);
                    default: taken = 1'b0;
                endcase
                e.pc_src = taken ? 2'd1 : 2'd0;
                e.imm_src = 3'd2;
                e.alu = rd1 - rd2;
            end
            7'h6F: begin
                e.reg_write = 1'b1;
                e.result_src = 3'd2;
                e.pc_src = 2'd1;
                e.imm_src = 3'd4;
                e.chk_alu = 1'b0;
            end
            7'h67: begin
                legal = (f3 == 3'd0);
                e.reg_write = 1'b1;
                e.result_src = 3'd2;
                e.pc_src = 2'd2;
                e.alu = rd1 + imm;
            end
            7'h37: begin
                e.reg_write = 1'b1;
                e.imm_src = 3'd3;
                e.alu = imm;
            end
            7'h17: begin
                e.reg_write = 1'b1;
                e.result_src = 3'd3;
                e.imm_src = 3'd3;
                e.chk_alu = 1'b0;
            end
            7'h0F: begin
                e.chk_alu = 1'b0;
                e.chk_imm = 1'b0;
            end
            7'h73: begin
                legal = (f3[1:0] != 2'd0);
                src = f3[2] ? {27'd0, ins[19:15]} : rd1;
                e.reg_write = 1'b1;
                e.csr_write = 1'b1;
                e.result_src = 3'd4;
                e.alu = (f3[1:0] == 2'd1) ? src : (f3[1:0] == 2'd2) ? (csrd | src) : (csrd & ~src);
                e.chk_imm = 1'b0;
            end
            default: legal = 1'b0;
        endcase
        if (!legal) begin
            e.illegal = 1'b1;
            e.reg_write = 1'b0;
            e.csr_write = 1'b0;
            e.mem_write = 4'b0000;
            e.result_src = 3'd0;
            e.data_ext = 3'd0;
            e.pc_src = 2'd0;
            e.chk_alu = 1'b0;
            e.chk_imm = 1'b0;
        end
        if (bubble) begin
            e = '0;
            e.chk_imm = legal && (ins[6:0] != 7'h33) && (ins[6:0] != 7'h0F) && (ins[6:0] != 7'h73);
            e.imm_src = ref_imm_src(ins[6:0]);
        end
        return e;
    endfunction

    function automatic logic [2:0] ref_imm_src(input logic [6:0] op);
        case (op)
            7'h23:        return 3'd1;
            7'h63:        return 3'd2;
            7'h37, 7'h17: return 3'd3;
            7'h6F:        return 3'd4;
            default:      return 3'd0;
        endcase
    endfunction

    task automatic issue(input logic [31:0] ins, input logic [31:0] pc, input logic [31:0] imm,
                         input logic [31:0] rd1, input logic [31:0] rd2, input logic [31:0] csrd,
                         input logic fl, input logic rn);
        @(negedge clk);
        bus.instr_d   = ins;
        bus.pc_d      = pc;
        bus.imm_ext_d = imm;
        bus.rd1_fw_e  = rd1;
        bus.rd2_fw_e  = rd2;
        bus.csrd_fw_e = csrd;
        bus.flush_e   = fl;
        rst_n         = rn;
        #1 imm_src_seen = bus.imm_src_d;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        issue(32'h0020A023, 32'h40, 32'h4, 32'h11, 32'h22, 32'h33, 1'b0, 1'b0);
        issue(32'h0020A023, 32'h40, 32'h4, 32'h11, 32'h22, 32'h33, 1'b0, 1'b0);
        n_cmp++; if (bus.mem_write_e !== 4'b0000) begin n_fail++; $display("FAIL reset mem_write_e got %b want 0000", bus.mem_write_e); end
        n_cmp++; if (bus.reg_write_e !== 1'b0 || bus.csr_write_e !== 1'b0 || bus.illegal_instr_e !== 1'b0) begin
            n_fail++; $display("FAIL reset ctl got rw=%b cw=%b il=%b want 0", bus.reg_write_e, bus.csr_write_e, bus.illegal_instr_e); end
        n_cmp++; if (bus.result_src_e !== 3'd0 || bus.pc_src_e !== 2'd0) begin
            n_fail++; $display("FAIL reset src got rs=%0d ps=%0d want 0", bus.result_src_e, bus.pc_src_e); end
        n_cmp++; if (bus.pc_target_e !== 32'd0 || bus.rs1_e !== 5'd0 || bus.rd_e !== 5'd0 || bus.csrs_e !== 12'd0) begin
            n_fail++; $display("FAIL reset fields got tgt=%h rs1=%0d rd=%0d csrs=%h want 0", bus.pc_target_e, bus.rs1_e, bus.rd_e, bus.csrs_e); end
    endtask

    task automatic test_add();
        issue(32'h002081B3, 32'h0, 32'h0, 32'd5, 32'd7, 32'd0, 1'b0, 1'b1);
        n_cmp++; if (bus.alu_result_e !== 32'd12) begin n_fail++; $display("FAIL add alu got %0d want 12", bus.alu_result_e); end
        n_cmp++; if (bus.reg_write_e !== 1'b1 || bus.rd_e !== 5'd3) begin
            n_fail++; $display("FAIL add rw/rd got %b/%0d want 1/3", bus.reg_write_e, bus.rd_e); end
        n_cmp++; if (bus.pc_src_e !== 2'd0) begin n_fail++; $display("FAIL add pc_src got %0d want 0", bus.pc_src_e); end
    endtask

    task automatic test_branch();
        issue(32'h0020C063, 32'h100, 32'h8, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b0, 1'b1);
        n_cmp++; if (bus.pc_src_e !== 2'd1) begin n_fail++; $display("FAIL blt pc_src got %0d want 1", bus.pc_src_e); end
        n_cmp++; if (bus.pc_target_e !== 32'h108) begin n_fail++; $display("FAIL blt target got %h want 00000108", bus.pc_target_e); end
        n_cmp++; if (bus.reg_write_e !== 1'b0) begin n_fail++; $display("FAIL blt reg_write got %b want 0", bus.reg_write_e); end
        issue(32'h0020E063, 32'h100, 32'h8, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b0, 1'b1);
        n_cmp++; if (bus.pc_src_e !== 2'd0) begin n_fail++; $display("FAIL bltu pc_src got %0d want 0", bus.pc_src_e); end
    endtask

    task automatic test_jalr();
        issue(32'h000080E7, 32'h80, 32'h0, 32'h2000, 32'h5, 32'd0, 1'b0, 1'b1);
        n_cmp++; if (bus.pc_src_e !== 2'd2) begin n_fail++; $display("FAIL jalr pc_src got %0d want 2", bus.pc_src_e); end
        n_cmp++; if (bus.alu_result_e !== 32'h2000) begin n_fail++; $display("FAIL jalr alu got %h want 00002000", bus.alu_result_e); end
        n_cmp++; if (bus.result_src_e !== 3'd2) begin n_fail++; $display("FAIL jalr result_src got %0d want 2", bus.result_src_e); end
    endtask

    task automatic test_csrrc();
        issue(32'h3000B0F3, 32'h0, 32'h0, 32'h0F, 32'h0, 32'hFF, 1'b0, 1'b1);
        n_cmp++; if (bus.alu_result_e !== 32'hF0) begin n_fail++; $display("FAIL csrrc alu got %h want 000000f0", bus.alu_result_e); end
        n_cmp++; if (bus.csr_write_e !== 1'b1 || bus.result_src_e !== 3'd4 || bus.csrs_e !== 12'h300) begin
            n_fail++; $display("FAIL csrrc ctl got cw=%b rs=%0d csrs=%h want 1/4/300", bus.csr_write_e, bus.result_src_e, bus.csrs_e); end
    endtask

    task automatic test_illegal();
        issue(32'hFFFFFFFF, 32'h0, 32'h0, 32'h1, 32'h2, 32'h3, 1'b0, 1'b1);
        n_cmp++; if (bus.illegal_instr_e !== 1'b1) begin n_fail++; $display("FAIL illegal flag got %b want 1", bus.illegal_instr_e); end
        n_cmp++; if (bus.reg_write_e !== 1'b0 || bus.csr_write_e !== 1'b0 || bus.mem_write_e !== 4'b0000 || bus.pc_src_e !== 2'd0) begin
            n_fail++; $display("FAIL illegal writes got rw=%b cw=%b mw=%b ps=%0d want 0", bus.reg_write_e, bus.csr_write_e, bus.mem_write_e, bus.pc_src_e); end
        issue(32'h00000073, 32'h0, 32'h0, 32'h1, 32'h2, 32'h3, 1'b0, 1'b1);
        n_cmp++; if (bus.illegal_instr_e !== 1'b1 || bus.reg_write_e !== 1'b0 || bus.csr_write_e !== 1'b0) begin
            n_fail++; $display("FAIL ecall got il=%b rw=%b cw=%b want 1/0/0", bus.illegal_instr_e, bus.reg_write_e, bus.csr_write_e); end
    endtask

    task automatic test_flush_reset();
        issue(32'h0020A023, 32'h0, 32'h4, 32'h10, 32'h20, 32'h0, 1'b0, 1'b1);
        n_cmp++; if (bus.mem_write_e !== 4'b1111) begin n_fail++; $display("FAIL sw mem_write got %b want 1111", bus.mem_write_e); end
        issue(32'h0020A023, 32'h0, 32'h4, 32'h10, 32'h20, 32'h0, 1'b1, 1'b1);
        n_cmp++; if (bus.mem_write_e !== 4'b0000) begin n_fail++; $display("FAIL sw flush mem_write got %b want 0000", bus.mem_write_e); end
        issue(32'h0000006F, 32'h0, 32'h40, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1);
        n_cmp++; if (bus.pc_src_e !== 2'd0 || bus.reg_write_e !== 1'b0) begin
            n_fail++; $display("FAIL jal flush got ps=%0d rw=%b want 0/0", bus.pc_src_e, bus.reg_write_e); end
        issue(32'h0020A023, 32'h0, 32'h4, 32'h10, 32'h20, 32'h0, 1'b0, 1'b0);
        n_cmp++; if (bus.mem_write_e !== 4'b0000) begin n_fail++; $display("FAIL sw reset mem_write got %b want 0000", bus.mem_write_e); end
        issue(32'h002081B3, 32'h0, 32'h0, 32'd1, 32'd2, 32'h0, 1'b0, 1'b1);
        n_cmp++; if (bus.reg_write_e !== 1'b1 || bus.alu_result_e !== 32'd3) begin
            n_fail++; $display("FAIL after reset got rw=%b alu=%0d want 1/3", bus.reg_write_e, bus.alu_result_e); end
    endtask

    task automatic test_random();
        logic [31:0] w, pc, imm, rd1, rd2, csrd;
        logic fl;
        exp_t e;
        for (int k = 0; k < 400; k++) begin
            w = $urandom;
            case ($urandom_range(0, 11))
                0:  w = {($urandom_range(0, 3) == 0) ? 7'h20 : 7'h00, w[24:7], 7'h33};
                1:  begin
                        w = {w[31:7], 7'h13};
                        if (w[13:12] == 2'b01) w[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
                    end
                2:  w = {w[31:7], 7'h03};
                3:  w = {w[31:15], 1'b0, w[13:7], 7'h23};
                4:  w = {w[31:15], (w[13] == 1'b0) ? {1'b0, w[13:12]} : {1'b1, w[13:12]}, w[11:7], 7'h63};
                5:  w = {w[31:7], 7'h6F};
                6:  w = {w[31:15], 3'b000, w[11:7], 7'h67};
                7:  w = {w[31:7], 7'h37};
                8:  w = {w[31:7], 7'h17};
                9:  w = {w[31:7], 7'h73};
                10: w = {w[31:7], 7'h0F};
                default: w = w;
            endcase
            pc   = $urandom;
            imm  = $urandom;
            rd1  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            rd2  = ($urandom_range(0, 3) == 0) ? rd1 : $urandom;
            csrd = $urandom;
            fl   = ($urandom_range(0, 9) == 0);
            e = ref_model(w, pc, imm, rd1, rd2, csrd, fl);
            issue(w, pc, imm, rd1, rd2, csrd, fl, 1'b1);
            n_cmp++; if (bus.illegal_instr_e !== e.illegal) begin n_fail++; $display("FAIL rnd%0d illegal ins=%h got %b want %b", k, w, bus.illegal_instr_e, e.illegal); end
            n_cmp++; if (bus.reg_write_e !== e.reg_write) begin n_fail++; $display("FAIL rnd%0d reg_write ins=%h got %b want %b", k, w, bus.reg_write_e, e.reg_write); end
            n_cmp++; if (bus.csr_write_e !== e.csr_write) begin n_fail++; $display("FAIL rnd%0d csr_write ins=%h got %b want %b", k, w, bus.csr_write_e, e.csr_write); end
            n_cmp++; if (bus.mem_write_e !== e.mem_write) begin n_fail++; $display("FAIL rnd%0d mem_write ins=%h got %b want %b", k, w, bus.mem_write_e, e.mem_write); end
            n_cmp++; if (bus.result_src_e !== e.result_src) begin n_fail++; $display("FAIL rnd%0d result_src ins=%h got %0d want %0d", k, w, bus.result_src_e, e.result_src); end
            n_cmp++; if (bus.data_ext_control_e !== e.data_ext) begin n_fail++; $display("FAIL rnd%0d data_ext ins=%h got %0d want %0d", k, w, bus.data_ext_control_e, e.data_ext); end
            n_cmp++; if (bus.pc_src_e !== e.pc_src) begin n_fail++; $display("FAIL rnd%0d pc_src ins=%h got %0d want %0d", k, w, bus.pc_src_e, e.pc_src); end
            n_cmp++; if (bus.pc_target_e !== e.pc_target) begin n_fail++; $display("FAIL rnd%0d pc_target ins=%h got %h want %h", k, w, bus.pc_target_e, e.pc_target); end
            n_cmp++; if ({bus.rs1_e, bus.rs2_e, bus.rd_e, bus.csrs_e} !== {e.rs1, e.rs2, e.rd, e.csrs}) begin
                n_fail++; $display("FAIL rnd%0d regfields ins=%h got %h want %h", k, w, {bus.rs1_e, bus.rs2_e, bus.rd_e, bus.csrs_e}, {e.rs1, e.rs2, e.rd, e.csrs}); end
            if (e.chk_alu) begin
                n_cmp++; if (bus.alu_result_e !== e.alu) begin n_fail++; $display("FAIL rnd%0d alu ins=%h got %h want %h", k, w, bus.alu_result_e, e.alu); end
            end
            if (e.chk_imm) begin
                n_cmp++; if (imm_src_seen !== e.imm_src) begin n_fail++; $display("FAIL rnd%0d imm_src ins=%h got %0d want %0d", k, w, imm_src_seen, e.imm_src); end
            end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_fail = 0;
        rst_n = 1'b0;
        bus.flush_e = 1'b0;
        bus.instr_d = 32'd0;
        bus.pc_d = 32'd0;
        bus.imm_ext_d = 32'd0;
        bus.rd1_fw_e = 32'd0;
        bus.rd2_fw_e = 32'd0;
        bus.csrd_fw_e = 32'd0;
        test_reset();
        test_add();
        test_branch();
        test_jalr();
        test_csrrc();
        test_illegal();
        test_flush_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/cpu_exec_unit.md
CPU_EXEC_UNIT -- requirements
Module: cpu_exec_unit

Interface
REQ-001 SHALL have ports; widths in bits; all non-clock/reset ports are data:
- clk, in, 1: clock; all state on rising edge.
- rst_n, in, 1: reset, synchronous, active-low.
- flush_e, in, 1: bubble the E register next edge.
- instr_d, in, 32: decode-stage instruction.
- pc_d, in, 32: decode-stage PC.
- imm_ext_d, in, 32: extended immediate, driven externally from imm_src_d.
- rd1_fw_e, rd2_fw_e, csrd_fw_e, in, 32 each: forwarded rs1, rs2 and CSR values in E.
- imm_src_d, out, 3: I=0, S=1, B=2, U=3, J=4.
- reg_write_e, csr_write_e, illegal_instr_e, out, 1 each: registered control.
- result_src_e, out, 3: ALU=0, DATA=1, PC_PLUS_4=2, PC_TARGET=3, CSR=4.
- mem_write_e, out, 4: byte enables; SB=0001, SH=0011, SW=1111, others 0000.
- data_ext_control_e, out, 3: load funct3.
- rs1_e, rs2_e, rd_e, out, 5 each; csrs_e, out, 12 (instr[31:20]).
- alu_result_e, pc_target_e, out, 32 each; pc_target_e = pc_e + imm_ext_e.
- pc_src_e, out, 2: PC+4=0, PC_TARGET=1, ALU=2.

Function
REQ-002 Decode SHALL be combinational from instr_d (op[6:0], funct3[14:12], funct7[31:25]); only imm_src_d is exported unregistered.
REQ-003 Per opcode, decoded fields SHALL be:
- R-type 0110011: funct7 0000000 or 0100000 (0100000 only for SUB/SRA); reg_write=1.
- I-ALU 0010011: src_b=IMM, imm I; SRAI when funct7=0100000.
- LOAD 0000011: ADD, result DATA, data_ext=funct3; funct3 in {000,001,010,100,101}.
- STORE 0100011: ADD, imm S, src_b=IMM, reg_write=0.
- BRANCH 1100011: SUB, imm B, branch=1, branch_cond=funct3.
- JAL 1101111: jump=1, jump_src=TARGET, result PC_PLUS_4, imm J.
- JALR 1100111: ADD, src_b=IMM, jump_src=ALU, result PC_PLUS_4.
- LUI 0110111: PASS_B of U imm.
- AUIPC 0010111: result PC_TARGET, imm U.
- FENCE 0001111: no-op, all writes 0.
- SYSTEM 1110011:
  - src_a=CSR; reg_write=1, csr_write=1, result CSR.
  - funct3 001/010/011: PASS_B/OR/ANDN with src_b=RD1.
  - funct3 101/110/111: same ops with src_b=RS1, zero-extended.
REQ-004 Any other opcode/funct combination, including ECALL/EBREAK, SHALL set illegal_instr=1 with reg_write, csr_write, mem_write, jump and branch all 0.
REQ-005 ALU src_a SHALL be rd1_fw_e (0) or csrd_fw_e (1); src_b SHALL be rd2_fw_e (0), imm_ext_e (1), rd1_fw_e (2), or zero-extended rs1_e (3).
REQ-006 alu_control SHALL be 4 bits:
- ADD=0, SUB=1, AND=2, OR=3, XOR=4.
- SLL=5, SRL=6, SRA=7: shift amount b[4:0].
- SLT=8, SLTU=9: result 0/1.
- PASS_B=10, ANDN=11 (a & ~b).
- Undefined codes yield 0.
REQ-007 ALU flags SHALL be combinational:
- zero = (result==0); neg = result[31].
- carry = bit 32 of a + ~b + 1 for SUB, else of a + b.
- overflow = signed overflow of the same add/sub; 0 for other ops.
REQ-008 Branch taken per branch_cond:
- 000: zero; 001: !zero.
- 100: neg^overflow; 101: !(neg^overflow).
- 110: !carry; 111: carry.
- 010, 011: never taken.
REQ-009 pc_src_e SHALL be:
- ALU (2) if jump_e and jump_src_e=ALU.
- PC_TARGET (1) if jump_e with TARGET, or branch_e and taken.
- PC+4 (0) otherwise.
REQ-010 When pc_src_e=ALU, the consumer SHALL use alu_result_e unmodified; bit 0 is not cleared here.
REQ-011 The E register SHALL capture all decoded fields, rs1/rs2/rd/csrs, pc_d and imm_ext_d every edge; there is no stall input.

Reset
REQ-012 On rst_n=0 or flush_e=1 at an edge, the E register SHALL load a bubble:
- reg_write=0, csr_write=0, mem_write=0000, jump=0, branch=0, illegal=0, result_src=ALU.
- All other fields 0.
REQ-013 After a bubble, pc_src_e SHALL be 0.
REQ-014 rst_n SHALL have priority over flush_e; reset mid-operation SHALL discard the in-flight instruction.

Verification
REQ-015 The bench SHALL cover these directed scenarios:
- ADD x3,x1,x2 (0x002081B3), rd1=5, rd2=7 -> next edge: alu_result_e=12, reg_write_e=1, rd_e=3, pc_src_e=0.
- BLT, rd1=0xFFFFFFFF, rd2=1, pc_d=0x100, imm=8 -> pc_src_e=1, pc_target_e=0x108; BLTU with same operands -> pc_src_e=0.
- JALR (0x000080E7), rd1=0x2000, imm=0 -> pc_src_e=2, alu_result_e=0x2000, result_src_e=2.
- CSRRC, csrd=0xFF, rd1=0x0F -> alu_result_e=0xF0, csr_write_e=1, result_src_e=4.
- instr 0xFFFFFFFF -> illegal_instr_e=1, all write enables 0.
- Assert flush_e or rst_n=0 with SW in decode -> mem_write_e=0000 next edge.
